// File: rtl/aud_pkt_pkg.sv
// Shared definitions for the UDP audio receive path: header field layout,
// FSM state encoding and the width used for saturating counter adds.
package aud_pkt_pkg;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hA5D0;

    // Header word 0 = {magic, seq}, header word 1 = {cnt, reserved}
    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 16;
    localparam int SEQ_HI   = 15;
    localparam int SEQ_LO   = 0;
    localparam int CNT_HI   = 31;
    localparam int CNT_LO   = 16;

    localparam int SEQ_W     = 16;
    localparam int SAT_ADD_W = SEQ_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_PAYLOAD,
        ST_TAIL,
        ST_DROP
    } state_e;

endpackage

// File: rtl/aud_seq_tracker.sv
// Tracks the last accepted sequence number and counts packets missing from the stream.
// lost_cnt is only built when AUD_DEPKT_STATS_EN is defined.
module aud_seq_tracker
    import aud_pkt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             eth_rx_clk,
    input  logic             rst_n,
    input  logic             hdr_acc,
    input  logic [SEQ_W-1:0] seq_in,
    output logic [SEQ_W-1:0] seq_num,
    output logic [CNT_W-1:0] lost_cnt
);

    logic             seq_valid_q, seq_valid_d;
    logic [SEQ_W-1:0] seq_num_q, seq_num_d;

    always_comb begin
        seq_valid_d = seq_valid_q;
        seq_num_d   = seq_num_q;
        if (hdr_acc) begin
            seq_valid_d = 1'b1;
            seq_num_d   = seq_in;
        end
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_valid_q <= 1'b0;
            seq_num_q   <= '0;
        end else begin
            seq_valid_q <= seq_valid_d;
            seq_num_q   <= seq_num_d;
        end
    end

    assign seq_num = seq_num_q;

`ifdef AUD_DEPKT_STATS_EN
    localparam int SUM_W = (CNT_W + 1 > SAT_ADD_W) ? CNT_W + 1 : SAT_ADD_W;

    logic [SEQ_W-1:0] gap;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;

    // A gap in the upper half of the sequence space is a duplicate or late packet.
    always_comb begin
        gap        = seq_in - seq_num_q - SEQ_W'(1);
        sum        = SUM_W'(lost_cnt_q) + SUM_W'(gap);
        lost_cnt_d = lost_cnt_q;
        if (hdr_acc && seq_valid_q && (gap != '0) && !gap[SEQ_W-1])
            lost_cnt_d = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) lost_cnt_q <= '0;
        else        lost_cnt_q <= lost_cnt_d;
    end

    assign lost_cnt = lost_cnt_q;
`else
    assign lost_cnt = '0;
`endif

endmodule

// File: rtl/udp_audio_depacketizer.sv
// Receive-side audio depacketizer: validates the 2-word header, streams samples to the
// playback FIFO and flags packet outcome. Statistics counters need AUD_DEPKT_STATS_EN.
module udp_audio_depacketizer
    import aud_pkt_pkg::*;
#(
    parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
    parameter int          MAX_SAMPLES = 256,
    parameter int          CNT_W       = 16
) (
    input  logic             eth_rx_clk,
    input  logic             rst_n,
    input  logic             rec_en,
    input  logic [31:0]      rec_data,
    input  logic             rec_pkt_done,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [31:0]      fifo_wr_data,
    output logic             pkt_ok,
    output logic             pkt_err,
    output logic [15:0]      seq_num,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int REM_W = $clog2(MAX_SAMPLES + 1);

    state_e           state_q, state_d, st_w;
    logic [REM_W-1:0] remaining_q, remaining_d;
    logic [SEQ_W-1:0] seq_lat_q, seq_lat_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic             pkt_err_q, pkt_err_d;
    logic             hdr_acc;
    logic [15:0]      hdr_cnt;
    logic             cnt_legal;

    assign hdr_cnt   = rec_data[CNT_HI:CNT_LO];
    assign cnt_legal = (hdr_cnt != '0) && (hdr_cnt <= 16'(MAX_SAMPLES));

    // st_w is the state after consuming this cycle's word; the close decision uses it
    // so a final sample arriving with rec_pkt_done still counts as a complete packet.
    always_comb begin
        st_w        = state_q;
        remaining_d = remaining_q;
        seq_lat_d   = seq_lat_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        pkt_ok_d    = 1'b0;
        pkt_err_d   = 1'b0;
        hdr_acc     = 1'b0;
        if (rec_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (rec_data[MAGIC_HI:MAGIC_LO] == MAGIC) begin
                        seq_lat_d = rec_data[SEQ_HI:SEQ_LO];
                        st_w      = ST_HDR1;
                    end else begin
                        st_w = ST_DROP;
                    end
                end
                ST_HDR1: begin
                    if (cnt_legal) begin
                        remaining_d = hdr_cnt[REM_W-1:0];
                        hdr_acc     = 1'b1;
                        st_w        = ST_PAYLOAD;
                    end else begin
                        st_w = ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    if (!fifo_full) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = rec_data;
                    end
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) st_w = ST_TAIL;
                end
                default: ;
            endcase
        end
        state_d = st_w;
        if (rec_pkt_done && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            if (st_w == ST_TAIL) pkt_ok_d  = 1'b1;
            else                 pkt_err_d = 1'b1;
        end
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            seq_lat_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            pkt_ok_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_lat_q   <= seq_lat_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign pkt_ok       = pkt_ok_q;
    assign pkt_err      = pkt_err_q;

    aud_seq_tracker #(.CNT_W(CNT_W)) u_seq (
        .eth_rx_clk (eth_rx_clk),
        .rst_n      (rst_n),
        .hdr_acc    (hdr_acc),
        .seq_in     (seq_lat_q),
        .seq_num    (seq_num),
        .lost_cnt   (lost_cnt)
    );

`ifdef AUD_DEPKT_STATS_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (pkt_err_d && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + CNT_W'(1);
        if ((state_q == ST_PAYLOAD) && rec_en && fifo_full && (ovf_cnt_q != '1))
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`else
    assign err_cnt = '0;
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_audio_depacketizer.sv
// Directed + randomized bench for udp_audio_depacketizer; counter expectations follow
// AUD_DEPKT_STATS_EN (zero when the statistics block is not built).
module tb_udp_audio_depacketizer;

    localparam logic [15:0] MAGIC = 16'hA5D0;
`ifdef AUD_DEPKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        eth_rx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rec_en = 1'b0;
    logic [31:0] rec_data = '0;
    logic        rec_pkt_done = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        pkt_ok, pkt_err;
    logic [15:0] seq_num, lost_cnt, err_cnt, ovf_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_sv;
    int          m_sn, m_lost, m_err, m_ovf;
    logic [31:0] pw [0:299];
    bit          pf [0:299];
    int          plen;
    bit          done_sep;
    int          gap_pct;

    always #5 eth_rx_clk = ~eth_rx_clk;

    udp_audio_depacketizer dut (
        .eth_rx_clk   (eth_rx_clk),
        .rst_n        (rst_n),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .pkt_ok       (pkt_ok),
        .pkt_err      (pkt_err),
        .seq_num      (seq_num),
        .lost_cnt     (lost_cnt),
        .err_cnt      (err_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "/seq_num"}, 32'(seq_num), 32'(m_sn));
        chk({tag, "/lost_cnt"}, 32'(lost_cnt), STATS ? 32'(m_lost) : 32'd0);
        chk({tag, "/err_cnt"}, 32'(err_cnt), STATS ? 32'(m_err) : 32'd0);
        chk({tag, "/ovf_cnt"}, 32'(ovf_cnt), STATS ? 32'(m_ovf) : 32'd0);
    endtask

    task automatic model_seq(input logic [15:0] seq);
        int gap;
        if (m_sv) begin
            gap = (int'(seq) - m_sn - 1) & 32'hFFFF;
            if (gap != 0 && gap < 32768) m_lost = sat16(m_lost + gap);
        end
        m_sv = 1'b1;
        m_sn = int'(seq);
    endtask

    task automatic build(input logic [15:0] magic, input logic [15:0] seq,
                         input logic [15:0] cnt, input int nsamp, input bit rnd);
        plen  = nsamp + 2;
        pw[0] = {magic, seq};
        pw[1] = {cnt, 16'h0};
        for (int k = 0; k < plen; k++) pf[k] = 1'b0;
        for (int k = 0; k < nsamp; k++) pw[k + 2] = rnd ? $urandom : 32'h11111111 * (k + 1);
        done_sep = 1'b0;
        gap_pct  = 0;
    endtask

    task automatic close_chk(input string tag, input bit exp_ok);
        chk({tag, "/pkt_ok"}, 32'(pkt_ok), 32'(exp_ok));
        chk({tag, "/pkt_err"}, 32'(pkt_err), 32'(!exp_ok));
        if (!exp_ok) m_err = sat16(m_err + 1);
    endtask

    // Drives the packet in pw/pf, checks every cycle, then checks the statistics.
    task automatic send_pkt(input string tag);
        bit acc, exp_wr, last_done, is_smp;
        int cnt;
        cnt = int'(pw[1][31:16]);
        acc = (pw[0][31:16] == MAGIC) && cnt >= 1 && cnt <= 256;
        for (int i = 0; i < plen; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                rec_en = 1'b0; rec_pkt_done = 1'b0; fifo_full = 1'($urandom_range(1));
                @(negedge eth_rx_clk);
                chk({tag, "/idle"}, {29'd0, fifo_wr_en, pkt_ok, pkt_err}, 32'd0);
            end
            last_done = (i == plen - 1) && !done_sep;
            rec_en = 1'b1; rec_data = pw[i]; fifo_full = pf[i]; rec_pkt_done = last_done;
            @(negedge eth_rx_clk);
            is_smp = acc && i >= 2 && (i - 2) < cnt;
            exp_wr = is_smp && !pf[i];
            chk({tag, "/wr_en"}, 32'(fifo_wr_en), 32'(exp_wr));
            if (exp_wr) chk({tag, "/wr_data"}, fifo_wr_data, pw[i]);
            if (is_smp && pf[i]) m_ovf = sat16(m_ovf + 1);
            if (acc && i == 1) model_seq(pw[0][15:0]);
            if (last_done) close_chk(tag, acc && (plen - 2) >= cnt);
            else chk({tag, "/no_pulse"}, {30'd0, pkt_ok, pkt_err}, 32'd0);
        end
        rec_en = 1'b0; rec_pkt_done = 1'b0; fifo_full = 1'b0;
        if (done_sep) begin
            rec_pkt_done = 1'b1;
            @(negedge eth_rx_clk);
            rec_pkt_done = 1'b0;
            chk({tag, "/sep_wr"}, 32'(fifo_wr_en), 32'd0);
            close_chk(tag, acc && (plen - 2) >= cnt);
        end
        @(negedge eth_rx_clk);
        chk_stats(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s, c, mg;
        int n;
        m_sv = 1'b0; m_sn = 0; m_lost = 0; m_err = 0; m_ovf = 0;

        repeat (2) @(negedge eth_rx_clk);
        chk("reset/outs", {27'd0, fifo_wr_en, pkt_ok, pkt_err, 2'b00}, 32'd0);
        chk("reset/wr_data", fifo_wr_data, 32'd0);
        chk_stats("reset");
        rst_n = 1'b1;
        @(negedge eth_rx_clk);

        build(MAGIC, 16'd1, 16'd4, 4, 1'b0);
        send_pkt("good");

        build(MAGIC, 16'd4, 16'd2, 2, 1'b0);
        send_pkt("gap");
        build(MAGIC, 16'd2, 16'd3, 3, 1'b0);
        send_pkt("late");

        build(16'h1234, 16'd5, 16'd4, 4, 1'b0);
        send_pkt("bad_magic");
        build(MAGIC, 16'd3, 16'd0, 2, 1'b0);
        send_pkt("cnt0");
        build(MAGIC, 16'd3, 16'd257, 2, 1'b0);
        send_pkt("cnt257");
        build(MAGIC, 16'd3, 16'd2, 2, 1'b0);
        send_pkt("after_bad");

        build(MAGIC, 16'd4, 16'd4, 2, 1'b0);
        send_pkt("short");
        build(MAGIC, 16'd5, 16'd2, 5, 1'b0);
        send_pkt("long");

        build(MAGIC, 16'd6, 16'd4, 4, 1'b0);
        pf[3] = 1'b1; pf[4] = 1'b1;
        send_pkt("fifo_full");

        build(MAGIC, 16'd7, 16'd256, 256, 1'b1);
        done_sep = 1'b1;
        send_pkt("max_cnt");

        // Reset in the middle of a payload
        build(MAGIC, 16'd50, 16'd4, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rec_en = 1'b1; rec_data = pw[i];
            @(negedge eth_rx_clk);
        end
        rec_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/outs", {29'd0, fifo_wr_en, pkt_ok, pkt_err}, 32'd0);
        m_sv = 1'b0; m_sn = 0; m_lost = 0; m_err = 0; m_ovf = 0;
        chk_stats("midrst");
        @(negedge eth_rx_clk);
        chk("midrst/held", {29'd0, fifo_wr_en, pkt_ok, pkt_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge eth_rx_clk);
        build(MAGIC, 16'd100, 16'd2, 2, 1'b0);
        send_pkt("post_rst");

        for (int p = 0; p < 40; p++) begin
            mg = MAGIC;
            if ($urandom_range(99) < 15) begin
                mg = 16'($urandom);
                if (mg == MAGIC) mg = ~mg;
            end
            s = 16'(m_sn + int'($urandom_range(0, 5)));
            if ($urandom_range(99) < 10) s = 16'($urandom);
            case ($urandom_range(9))
                0:       c = 16'd0;
                1:       c = 16'(257 + $urandom_range(0, 1000));
                default: c = 16'($urandom_range(1, 8));
            endcase
            n = (c >= 1 && c <= 8) ? int'($urandom_range(0, int'(c) + 2)) : int'($urandom_range(0, 4));
            build(mg, s, c, n, 1'b1);
            for (int k = 2; k < plen; k++) pf[k] = ($urandom_range(99) < 25);
            done_sep = ($urandom_range(99) < 30);
            gap_pct  = 20;
            send_pkt("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/udp_audio_depacketizer.md
Name: udp_audio_depacketizer

Overview:
- Receive-side counterpart of the board's audio packetizer.
- Sits between the UDP receive user interface (rec_en/rec_data/rec_pkt_done) and the write port of the audio playback FIFO, all in the eth_rx_clk domain.
- Validates a 2-word audio header, streams the payload samples into the FIFO, tracks packet sequence numbers to count lost packets, and flags malformed packets.

Parameters:
- MAGIC, 16'hA5D0, required value of header word 0 bits [31:16].
- MAX_SAMPLES, 256, largest legal sample count per packet.
- CNT_W, 16, width of the statistics counters.

Ports:
- eth_rx_clk  input  1  receive clock; all logic runs on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rec_en  input  1  one-cycle strobe; rec_data is valid this cycle.
- rec_data  input  32  received UDP payload word, first byte in [31:24].
- rec_pkt_done  input  1  one-cycle pulse: UDP packet ended; may coincide with the last rec_en.
- fifo_full  input  1  playback FIFO full.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  32  sample word {L[15:0],R[15:0]}.
- pkt_ok  output  1  one-cycle pulse: complete valid packet.
- pkt_err  output  1  one-cycle pulse: malformed or short packet.
- seq_num  output  16  sequence number of the last accepted header.
- lost_cnt  output  CNT_W  packets missing from the sequence.
- err_cnt  output  CNT_W  pkt_err events.
- ovf_cnt  output  CNT_W  samples dropped because fifo_full.

Behaviour:
- Reset state:
  - FSM is IDLE.
  - All outputs are 0, and the seq_valid flag is cleared.
  - Reset asserted mid-packet abandons the packet with no pulses and no write.
- Packet format:
  - Word 0 is {MAGIC, seq[15:0]}.
  - Word 1 is {cnt[15:0], 16'h0}.
  - Words 2 to cnt+1 are samples.
- FSM states and transitions:
  - IDLE: on rec_en, if rec_data[31:16]==MAGIC, latch seq and go to HDR1. Otherwise go to DROP and mark the packet bad.
  - HDR1: on rec_en, if cnt==0 or cnt>MAX_SAMPLES, go to DROP and mark bad. Otherwise load remaining=cnt, perform the sequence check, and go to PAYLOAD.
  - PAYLOAD: on each rec_en, if fifo_full==0, write the word; if full, drop the word and increment ovf_cnt. Either way, decrement remaining. When remaining reaches 0, go to TAIL.
  - TAIL: excess words are ignored silently, with no error.
  - DROP: all words are ignored.
- Packet close:
  - rec_pkt_done in any non-IDLE state closes the packet and returns to IDLE next cycle.
  - pkt_ok pulses if the state was TAIL, or if it was PAYLOAD and the final word arrived in that same cycle.
  - Otherwise pkt_err pulses and err_cnt increments. This covers DROP, HDR1, and short PAYLOAD.
  - rec_pkt_done in IDLE is ignored.
- Simultaneous rec_en and rec_pkt_done: the word is processed first, then the packet is closed on that same edge.
- Short packets:
  - Samples already written stay in the FIFO; there is no rollback.
  - pkt_err pulses.
- Write latency:
  - fifo_wr_en and fifo_wr_data are registered and asserted the cycle after the accepted rec_en.
  - At most one write per cycle.
- Sequence check at HDR1 acceptance:
  - If seq_valid==0: set seq_valid and load seq_num; no loss is counted.
  - Otherwise compute gap = (seq - seq_num - 1) mod 2^16.
  - If 0 < gap < 16'h8000: lost_cnt += gap.
  - If gap >= 16'h8000 (duplicate or late packet): lost_cnt is unchanged. The packet is still played.
  - seq_num takes the new seq in every case.
- Counters:
  - All counters saturate at all-ones and never wrap.
  - lost_cnt is added with saturation.
- pkt_ok and pkt_err are never asserted in the same cycle.

Optional Feature:
- Macro: AUD_DEPKT_STATS_EN.
- Defined: lost_cnt, err_cnt and ovf_cnt are implemented as described above.
- Undefined:
  - The counter registers and gap adder are omitted, and lost_cnt, err_cnt and ovf_cnt are tied to 0.
  - pkt_ok, pkt_err, seq_num and the FIFO writes are unchanged.

Decomposition:
- Package aud_pkt_pkg holds:
  - MAGIC default, header word indices and field bit ranges;
  - the FSM state encoding (IDLE, HDR1, PAYLOAD, TAIL, DROP);
  - the saturating-add width constant.
- One natural sub-module: aud_seq_tracker. It holds seq_valid, seq_num, the gap computation and lost_cnt; it takes a header-accept strobe plus seq.

Test Plan:
- Good packet: word0 A5D0_0001, word1 0004_0000, samples 0x11111111 to 0x44444444, with rec_pkt_done on the last word. Expect 4 writes in order, each 1 cycle after its rec_en; one pkt_ok; seq_num=1; lost_cnt=0.
- Sequence gap: seq 1 then seq 4. Expect lost_cnt=2. Then send seq 2 (late). Expect lost_cnt to stay 2, seq_num=2, and the samples to be written.
- Bad magic (word0 1234_0005), then a bad count (cnt=0) and another bad count (cnt=257). Expect no writes, 3 pkt_err pulses and err_cnt=3; the next valid packet is accepted.
- Short and long packets: cnt=4 with 2 samples then rec_pkt_done. Expect 2 writes and pkt_err. Then cnt=2 with 5 samples. Expect 2 writes, pkt_ok and no error.
- FIFO full asserted during samples 2-3 of 4. Expect 2 writes and ovf_cnt=2; pkt_ok still pulses.
- Reset pulse mid-PAYLOAD. Expect all outputs 0 immediately, seq_valid cleared and no pulse; the next packet is treated as the first (lost_cnt=0).
